// File: rtl/updown_counter_param_if.sv
// Purpose: control and status bundle for updown_counter_param. The master
//          drives enable/direction/step/load/load_value/clear_flags. The slave
//          returns the count dout, tc, the sticky flags and the at_max/at_min
//          indications.
// Latency: none; this file only groups wires.
// Backpressure: none; the counter accepts a command on every edge.
interface updown_counter_param_if #(
    parameter int WIDTH      = 6,
    parameter int STEP_WIDTH = 3
);
    logic                  enable;
    logic                  direction;
    logic [STEP_WIDTH-1:0] step;
    logic                  load;
    logic [WIDTH-1:0]      load_value;
    logic                  clear_flags;
    logic [WIDTH-1:0]      dout;
    logic                  tc;
    logic                  overflow;
    logic                  underflow;
    logic                  at_max;
    logic                  at_min;

    modport master (
        output enable, direction, step, load, load_value, clear_flags,
        input  dout, tc, overflow, underflow, at_max, at_min
    );

    modport slave (
        input  enable, direction, step, load, load_value, clear_flags,
        output dout, tc, overflow, underflow, at_max, at_min
    );
endinterface

// File: rtl/updown_counter_param.sv
// Purpose: parametrised up/down counter. It supports a step size, a synchronous
//          load, and either wrap or saturate at 0 and MAX_VALUE.
// Latency: dout, tc and the flags are valid 1 cycle after the qualifying edge.
//          at_max and at_min follow dout combinationally.
// Backpressure: none. Priority on each edge is reset, then load, then enable,
//          then hold.
// Ports:   CLK   rising-edge clock.
//          reset asynchronous reset, active low.
//          bus   slave side of updown_counter_param_if.
module updown_counter_param #(
    parameter int WIDTH      = 6,
    parameter int MAX_VALUE  = 63,
    parameter int STEP_WIDTH = 3,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                   CLK,
    input  logic                   reset,
    updown_counter_param_if.slave  bus
);
    // Two guard bits: WIDTH+1 bits could be too narrow for MAX_VALUE + step,
    // and the range checks must see the untruncated sum.
    localparam int             EW    = WIDTH + 2;
    localparam logic [EW-1:0]  MAX_E = EW'(MAX_VALUE);
    localparam logic [EW-1:0]  MOD_E = EW'(MAX_VALUE + 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [EW-1:0]    cur_e, step_e, load_e, up_sum;
    logic [WIDTH-1:0] up_wrap, dn_wrap, dn_diff;
    logic             count_up, count_dn, up_cross, dn_cross;

    always_comb begin
        cur_e    = {2'b00, dout_q};
        step_e   = EW'(bus.step);
        load_e   = {2'b00, bus.load_value};
        up_sum   = cur_e + step_e;
        up_wrap  = WIDTH'(up_sum - MOD_E);
        dn_wrap  = WIDTH'(cur_e + MOD_E - step_e);
        dn_diff  = WIDTH'(cur_e - step_e);

        // Load takes priority, so enable has no effect in a load cycle.
        count_up = bus.enable & ~bus.load & ~bus.direction;
        count_dn = bus.enable & ~bus.load &  bus.direction;

        // A counter that is already saturated at a boundary also meets these
        // tests whenever step > 0. That counts as a crossing, so tc and the
        // flag still fire. A step of 0 can never cross.
        up_cross = count_up & (up_sum > MAX_E);
        dn_cross = count_dn & (step_e > cur_e);

        dout_d = dout_q;
        if (bus.load) begin
            dout_d = (load_e > MAX_E) ? MAX_W : bus.load_value;
        end else if (count_up) begin
            if (up_cross) dout_d = SATURATE ? MAX_W : up_wrap;
            else          dout_d = up_sum[WIDTH-1:0];
        end else if (count_dn) begin
            if (dn_cross) dout_d = SATURATE ? '0 : dn_wrap;
            else          dout_d = dn_diff;
        end

        tc_d  = up_cross | dn_cross;
        // If a set and a clear occur on the same edge, the set wins.
        ovf_d = (ovf_q & ~bus.clear_flags) | up_cross;
        unf_d = (unf_q & ~bus.clear_flags) | dn_cross;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            tc_q   <= tc_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.tc        = tc_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.at_max    = (dout_q == MAX_W);
    assign bus.at_min    = (dout_q == '0);
endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;
    typedef struct packed {
        logic [5:0] dout;
        logic       tc;
        logic       ov;
        logic       un;
        logic       amax;
        logic       amin;
    } obs_t;

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    logic       en  = 1'b0;
    logic       dir = 1'b0;
    logic       ld  = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] stp = 3'd0;
    logic [5:0] lv  = 6'd0;

    // Three units run the same stimulus: default wrap, saturate, and decade.
    updown_counter_param_if #(.WIDTH(6), .STEP_WIDTH(3)) bus0 ();
    updown_counter_param_if #(.WIDTH(6), .STEP_WIDTH(3)) bus1 ();
    updown_counter_param_if #(.WIDTH(4), .STEP_WIDTH(3)) bus2 ();

    assign bus0.enable = en;  assign bus0.direction = dir; assign bus0.step = stp;
    assign bus0.load = ld;    assign bus0.load_value = lv; assign bus0.clear_flags = clr;
    assign bus1.enable = en;  assign bus1.direction = dir; assign bus1.step = stp;
    assign bus1.load = ld;    assign bus1.load_value = lv; assign bus1.clear_flags = clr;
    assign bus2.enable = en;  assign bus2.direction = dir; assign bus2.step = stp;
    assign bus2.load = ld;    assign bus2.load_value = lv[3:0]; assign bus2.clear_flags = clr;

    updown_counter_param #(.WIDTH(6), .MAX_VALUE(63), .STEP_WIDTH(3), .SATURATE(1'b0))
        u_wrap (.CLK(CLK), .reset(reset), .bus(bus0));
    updown_counter_param #(.WIDTH(6), .MAX_VALUE(63), .STEP_WIDTH(3), .SATURATE(1'b1))
        u_sat (.CLK(CLK), .reset(reset), .bus(bus1));
    updown_counter_param #(.WIDTH(4), .MAX_VALUE(9), .STEP_WIDTH(3), .SATURATE(1'b0))
        u_dec (.CLK(CLK), .reset(reset), .bus(bus2));

    int errors = 0;
    int checks = 0;

    // Reference model state, one entry per unit.
    int maxv[3]   = '{63, 63, 9};
    int sat[3]    = '{0, 1, 0};
    int lvmask[3] = '{63, 63, 15};
    int m_d[3]    = '{0, 0, 0};
    int m_tc[3]   = '{0, 0, 0};
    int m_ov[3]   = '{0, 0, 0};
    int m_un[3]   = '{0, 0, 0};

    obs_t exp_q[$];

    function automatic obs_t model_obs(input int i);
        obs_t o;
        o.dout = 6'(m_d[i]);
        o.tc   = (m_tc[i] != 0);
        o.ov   = (m_ov[i] != 0);
        o.un   = (m_un[i] != 0);
        o.amax = (m_d[i] == maxv[i]);
        o.amin = (m_d[i] == 0);
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_d[i] = 0; m_tc[i] = 0; m_ov[i] = 0; m_un[i] = 0;
        end
    endtask

    task automatic model_step();
        int d, s, v;
        for (int i = 0; i < 3; i++) begin
            d = m_d[i];
            s = int'(stp);
            if (clr) begin m_ov[i] = 0; m_un[i] = 0; end
            m_tc[i] = 0;
            if (ld) begin
                v = int'(lv) & lvmask[i];
                m_d[i] = (v > maxv[i]) ? maxv[i] : v;
            end else if (en && !dir) begin
                if (d + s > maxv[i]) begin
                    m_tc[i] = 1; m_ov[i] = 1;
                    m_d[i] = sat[i] ? maxv[i] : (d + s) % (maxv[i] + 1);
                end else begin
                    m_d[i] = d + s;
                end
            end else if (en && dir) begin
                if (s > d) begin
                    m_tc[i] = 1; m_un[i] = 1;
                    m_d[i] = sat[i] ? 0 : (d - s + maxv[i] + 1) % (maxv[i] + 1);
                end else begin
                    m_d[i] = d - s;
                end
            end
        end
    endtask

    task automatic push_all();
        for (int i = 0; i < 3; i++) exp_q.push_back(model_obs(i));
    endtask

    task automatic check_all(input string tag);
        obs_t o[3];
        obs_t e;
        o[0] = {bus0.dout, bus0.tc, bus0.overflow, bus0.underflow, bus0.at_max, bus0.at_min};
        o[1] = {bus1.dout, bus1.tc, bus1.overflow, bus1.underflow, bus1.at_max, bus1.at_min};
        o[2] = {2'b00, bus2.dout, bus2.tc, bus2.overflow, bus2.underflow, bus2.at_max, bus2.at_min};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL %s unit%0d: scoreboard empty, observed=%h", tag, i, o[i]);
            end else begin
                e = exp_q.pop_front();
                assert (o[i] === e) else begin
                    errors++;
                    $error("FAIL %s unit%0d: observed dout=%0d tc/ov/un/max/min=%b required dout=%0d tc/ov/un/max/min=%b",
                           tag, i, o[i].dout, o[i][4:0], e.dout, e[4:0]);
                end
            end
        end
    endtask

    task automatic cyc(input string tag);
        model_step();
        push_all();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic e_, input logic d_, input logic [2:0] s_,
                          input logic l_, input logic [5:0] v_, input logic c_);
        en = e_; dir = d_; stp = s_; ld = l_; lv = v_; clr = c_;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, checked before any clock edge.
        #2;
        model_reset(); push_all(); check_all("reset");
        #1 reset = 1'b1;

        // Count up by 1 across the wrap and saturate boundaries.
        set_in(1, 0, 3'd1, 0, 6'd0, 0);
        for (int k = 0; k < 70; k++) cyc($sformatf("up1_c%0d", k));

        // Step 0 while enabled, then step 5 while disabled: the count holds.
        set_in(1, 0, 3'd0, 0, 6'd0, 0);
        for (int k = 0; k < 4; k++) cyc($sformatf("step0_c%0d", k));
        set_in(0, 1, 3'd5, 0, 6'd0, 0);
        for (int k = 0; k < 4; k++) cyc($sformatf("disabled_c%0d", k));

        // Down-wrap from 2 by 5, clear alone, then clear together with a set.
        set_in(0, 0, 3'd0, 1, 6'd2, 0); cyc("load2");
        set_in(1, 1, 3'd5, 0, 6'd0, 0); cyc("down_wrap");
        set_in(0, 0, 3'd0, 0, 6'd0, 1); cyc("clear_alone");
        set_in(0, 0, 3'd0, 1, 6'd2, 0); cyc("reload2");
        set_in(1, 1, 3'd5, 0, 6'd0, 1); cyc("clear_vs_set");
        set_in(0, 0, 3'd0, 0, 6'd0, 0); cyc("hold_after_set");

        // Large up steps from 60, then a down step of 7 from 3.
        set_in(0, 0, 3'd0, 1, 6'd60, 0); cyc("load60");
        set_in(1, 0, 3'd7, 0, 6'd0, 0);
        for (int k = 0; k < 3; k++) cyc($sformatf("up7_c%0d", k));
        set_in(0, 0, 3'd0, 1, 6'd3, 0); cyc("load3");
        set_in(1, 1, 3'd7, 0, 6'd0, 0); cyc("down7_from3");
        set_in(1, 1, 3'd7, 0, 6'd0, 0); cyc("down7_again");

        // Load clamp, and load winning over enable.
        set_in(0, 0, 3'd0, 1, 6'd14, 0); cyc("load14");
        set_in(1, 0, 3'd7, 1, 6'd4, 0);  cyc("load_over_enable");
        set_in(0, 0, 3'd0, 1, 6'd8, 0);  cyc("load8");
        set_in(1, 0, 3'd1, 0, 6'd0, 0);
        for (int k = 0; k < 3; k++) cyc($sformatf("dec_wrap_c%0d", k));

        // Asynchronous reset pulse between edges while mid-count with flags set.
        set_in(0, 0, 3'd0, 1, 6'd37, 0); cyc("load37");
        set_in(1, 0, 3'd1, 1, 6'd37, 0); cyc("load37_inflight");
        #2 reset = 1'b0;
        #1;
        model_reset(); push_all(); check_all("async_reset");
        #2 reset = 1'b1;
        set_in(1, 0, 3'd1, 0, 6'd0, 0);
        for (int k = 0; k < 3; k++) cyc($sformatf("resume_c%0d", k));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter. It is the successor to the fixed 6-bit +1/−1 adder-mux-register counter.
- Adds over that counter: configurable width and modulus, variable step size, synchronous load, count enable, and selectable wrap or saturate mode.
- Reports boundary events through a terminal-count pulse and sticky overflow/underflow flags.
- Used wherever the datapath labs need a programmable loop, address or decade counter.

Parameters:
WIDTH, 6, counter width in bits.
MAX_VALUE, 63, highest legal count. Constraint: MAX_VALUE <= 2^WIDTH−1.
STEP_WIDTH, 3, width of the step input. Constraint: 2^STEP_WIDTH−1 <= MAX_VALUE.
SATURATE, 0, boundary mode: 0 = wrap modulo MAX_VALUE+1; 1 = clamp at 0 / MAX_VALUE.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
enable  input  1  count enable.
direction  input  1  0 = count up, 1 = count down.
step  input  STEP_WIDTH  magnitude added or subtracted per enabled cycle.
load  input  1  synchronous load strobe.
load_value  input  WIDTH  value to load.
clear_flags  input  1  synchronous clear of the sticky flags.
dout  output  WIDTH  current count (registered).
tc  output  1  registered terminal-count pulse.
overflow  output  1  sticky flag: an up-count crossed MAX_VALUE.
underflow  output  1  sticky flag: a down-count crossed 0.
at_max  output  1  combinational: dout == MAX_VALUE.
at_min  output  1  combinational: dout == 0.

Behaviour:
- Reset state:
  - reset=0 forces dout=0, tc=0, overflow=0, underflow=0 immediately, independent of CLK.
  - After reset, at_min=1 and at_max=0 (at_max=1 only if MAX_VALUE=0, which is disallowed).
  - Deassertion is synchronised by the user; no internal synchroniser.
- Per-edge priority: reset > load > enable > hold.
- load=1:
  - dout <= min(load_value, MAX_VALUE). Out-of-range load values clamp to MAX_VALUE.
  - tc <= 0.
  - enable, direction and step are ignored that cycle.
- enable=1, load=0, step=0: dout holds, tc <= 0. This is not a boundary event.
- Arithmetic: the next value is computed at WIDTH+2 bits; no truncation before the range check.
- Up, crossing: dout+step > MAX_VALUE.
  - Wrap: dout <= dout+step−(MAX_VALUE+1).
  - Saturate: dout <= MAX_VALUE.
- Down, crossing: step > dout.
  - Wrap: dout <= dout+(MAX_VALUE+1)−step.
  - Saturate: dout <= 0.
- Non-crossing: dout <= dout±step.
- Saturate mode already sitting at a boundary (up at MAX_VALUE, or down at 0, with step>0):
  - Counts as a crossing: tc pulses and the flag sets.
  - dout is unchanged.
- tc: 1 for exactly the cycle after any crossing edge; 0 otherwise. Consecutive crossings give consecutive tc highs.
- Sticky flags:
  - overflow sets on an up crossing; underflow sets on a down crossing.
  - Both clear on clear_flags=1.
  - If a set and a clear occur on the same edge, the set wins.
  - Flags are unaffected by load.
- Latency: dout and tc are valid 1 cycle after the qualifying edge. at_max and at_min follow dout combinationally.
- direction or step changing between cycles takes effect on the next enabled edge; there is no pipelining.
- Reset asserted mid-count (including during load): state goes to zero at once, and the in-flight operation is discarded.

Test Plan:
1. Default params, reset released, enable=1, dir=0, step=1, 70 cycles -> dout 0,1,…,63,0,1,…; tc=1 on the cycle dout shows 0 after 63; overflow=1 thereafter; at_max=1 only when dout=63.
2. Default params, dout=2, dir=1, step=5 -> dout=61, tc pulse, underflow=1; then clear_flags=1 alone -> underflow=0; then clear_flags=1 together with another down-wrap -> underflow stays 1.
3. SATURATE=1, dout=60, dir=0, step=7, 3 enabled cycles -> dout 63,63,63 with tc high all 3 cycles; then dir=1, step=7 from dout=3 -> dout=0, underflow=1.
4. MAX_VALUE=9, WIDTH=4, STEP_WIDTH=3 (decade) -> up-count step 1 wraps 9→0 with tc; load_value=14 -> dout=9 (clamped); load=1 and enable=1 together with load_value=4 -> dout=4 with no step applied and tc=0.
5. Mid-count at dout=37 with overflow=1, pulse reset=0 for 3 ns between edges -> dout=0 and flags=0 immediately; counting resumes from 0 on the first edge after release.
6. enable=1, step=0, and enable=0 with step=5, each for 4 cycles -> dout unchanged and tc=0 throughout.
